decifra: RTL and testbench
==========================

DECIFRA -- requirements
Module: decifra

Interface
REQ-001 Parameter ALPHA, default 26, alphabet size; legal codes are 0..ALPHA-1.
REQ-002 Parameter DEPTH, default 4, output FIFO depth in entries, power of two.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-005 key_load  in  1  request to load key_in as the new shift key.
REQ-006 key_in  in  5  shift key, legal range 0..ALPHA-1.
REQ-007 key_err  out  1  one-cycle pulse when a key_load is rejected.
REQ-008 in_valid  in  1  cipher code present on in_code.
REQ-009 in_ready  out  1  block can accept a code this cycle.
REQ-010 in_code  in  5  cipher letter code.
REQ-011 out_valid  out  1  FIFO head is valid.
REQ-012 out_ready  in  1  consumer takes the FIFO head this cycle.
REQ-013 out_code  out  5  deciphered letter code at the FIFO head.
REQ-014 out_err  out  1  FIFO head came from an illegal input code.
REQ-015 char_cnt  out  8  count of accepted codes, saturating at 255.

Function
REQ-016 FSM states: IDLE (no key loaded), RUN, DRAIN.
REQ-017 IDLE: in_ready=0; key_load with key_in<ALPHA stores the key and moves to RUN next cycle.
REQ-018 RUN: in_ready=1 when FIFO count<DEPTH and key_load=0, otherwise 0.
REQ-019 A transfer occurs when in_valid&in_ready is high at a clock edge; it pushes one FIFO entry.
REQ-020 Legal in_code: entry = (in_code - key) mod ALPHA, computed in 6 bits with a single conditional +ALPHA wrap; out_err=0.
REQ-021 Illegal in_code (>=ALPHA): entry = in_code unchanged, out_err=1.
REQ-022 Latency: a code accepted at edge N is at the FIFO head with out_valid=1 after edge N when the FIFO was empty; no combinational in-to-out path.
REQ-023 Pop occurs when out_valid&out_ready is high at a clock edge; FIFO order is strict.
REQ-024 Simultaneous push and pop when not full: count unchanged, both take effect; when full, in_ready=0 even if out_ready=1 (no bypass).
REQ-025 Pop while empty is ignored; out_code/out_err hold their last value while out_valid=0.
REQ-026 key_load in RUN with legal key_in: FIFO empty -> key replaced at that edge, stay in RUN; FIFO non-empty -> key captured as pending, move to DRAIN.
REQ-027 DRAIN: in_ready=0; on the edge the FIFO becomes empty, the pending key becomes active and state returns to RUN.
REQ-028 Entries already in the FIFO are never recomputed with a new key.
REQ-029 key_load with key_in>=ALPHA in any state: ignored, key_err=1 for that cycle, state unchanged.
REQ-030 key_load in DRAIN with legal key_in overwrites the pending key.
REQ-031 char_cnt increments on every transfer (legal or illegal) and holds at 255.

Reset
REQ-032 reset=0 forces, immediately and regardless of clk: state=IDLE, key=0, pending key=0, FIFO empty, pointers=0.
REQ-033 Outputs during and after reset: in_ready=0, out_valid=0, out_code=0, out_err=0, key_err=0, char_cnt=0.
REQ-034 Reset mid-operation discards all FIFO contents and the loaded key; a key_load is required again.

Structure
REQ-035 Package decifra_pkg holds ALPHA, code width 5, the FSM state enumeration and the mod-ALPHA subtract function.
REQ-036 The FIFO is the sub-module decifra_fifo (DEPTH, width 6 = code+err, count output), same clock and reset.

Verification
REQ-037 Reset, key_load key_in=3, send in_code 3,0,25 -> out_code 0,23,22, out_err=0, char_cnt=3.
REQ-038 Key 0, in_code 30 -> out_code 30, out_err=1; key_load key_in=26 -> key_err 1-cycle pulse, key unchanged.
REQ-039 Key 5, out_ready=0, push 5 codes -> in_ready falls after 4, 5th held; one pop -> accepted next cycle.
REQ-040 Key 1, two codes queued, key_load 2 -> DRAIN, in_ready=0; outputs use key 1; after empty, code 4 -> 2.
REQ-041 Full FIFO with in_valid=1, reset pulsed low between edges -> out_valid=0 and in_ready=0 at once; IDLE until a new key.
REQ-042 300 transfers with out_ready=1 -> char_cnt saturates at 255; FIFO order and values correct throughout.

Source files
------------

// File: rtl/decifra_pkg.sv
// Shared constants, FSM state encoding and the mod-ALPHA subtract helper for decifra.
// The subtract assumes both operands are already below alpha.
package decifra_pkg;

    localparam int DEC_ALPHA = 26;
    localparam int CODE_W    = 5;
    localparam int ENTRY_W   = CODE_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One extra bit holds the borrow; a single +alpha brings it back into range.
    function automatic logic [CODE_W-1:0] mod_sub(
        input logic [CODE_W-1:0] code,
        input logic [CODE_W-1:0] key,
        input logic [CODE_W:0]   alpha
    );
        logic [CODE_W:0] diff;
        diff = {1'b0, code} - {1'b0, key};
        if (diff[CODE_W]) begin
            diff = diff + alpha;
        end
        return diff[CODE_W-1:0];
    endfunction

endpackage

// File: rtl/decifra_fifo.sv
// Output FIFO for decifra: power-of-two depth, registered storage, head output
// holds the most recently popped entry while the FIFO is empty.
module decifra_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 6,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : hold_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                hold_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/decifra.sv
// Shift-cipher decoder: subtracts the loaded key from each incoming code and
// queues the result; a key change waits for already-queued results to drain.
//
// state    | meaning
// ST_IDLE  | no key loaded, input blocked
// ST_RUN   | key active, codes accepted while FIFO has room
// ST_DRAIN | new key pending, input blocked until FIFO empties
module decifra
    import decifra_pkg::*;
#(
    parameter int ALPHA = DEC_ALPHA,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [CODE_W-1:0] key_in,
    output logic              key_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_err,
    output logic [7:0]        char_cnt
);

    localparam logic [CODE_W:0] ALPHA_V = (CODE_W+1)'(ALPHA);
    localparam int              CNT_W   = $clog2(DEPTH) + 1;

    state_t             state_q;
    logic [CODE_W-1:0]  key_q;
    logic [CODE_W-1:0]  pend_q;
    logic [7:0]         cnt_q;

    logic               key_legal;
    logic               key_ok;
    logic               code_legal;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drained;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [ENTRY_W-1:0] entry_d;
    logic [ENTRY_W-1:0] head;

    assign key_legal  = ({1'b0, key_in} < ALPHA_V);
    assign key_ok     = key_load && key_legal;
    assign code_legal = ({1'b0, in_code} < ALPHA_V);

    assign in_ready = (state_q == ST_RUN) && !fifo_full && !key_load;
    // Rejection is flagged in the same cycle as the offending key_load.
    assign key_err  = reset && key_load && !key_legal;

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign fifo_empty = (fifo_cnt == '0);
    assign drained    = fifo_empty || (pop && fifo_cnt == CNT_W'(1));

    assign entry_d = code_legal ? {1'b0, mod_sub(in_code, key_q, ALPHA_V)}
                                : {1'b1, in_code};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (push && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (key_ok) begin
                        key_q   <= key_in;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (key_ok) begin
                        if (fifo_empty) begin
                            key_q <= key_in;
                        end else begin
                            pend_q  <= key_in;
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A legal key arriving on the draining edge wins over the pending one.
                    if (drained) begin
                        key_q   <= key_ok ? key_in : pend_q;
                        state_q <= ST_RUN;
                    end else if (key_ok) begin
                        pend_q <= key_in;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    decifra_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (entry_d),
        .rdata_o (head),
        .valid_o (out_valid),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    assign out_code = head[CODE_W-1:0];
    assign out_err  = head[CODE_W];
    assign char_cnt = cnt_q;

endmodule

// File: tb/tb_decifra.sv
// Directed bench for decifra: hand-computed vectors for key handling, FIFO
// back-pressure, drain-on-key-change, reset mid-traffic and counter saturation.
module tb_decifra;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_load;
    logic [4:0] key_in;
    logic       key_err;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_code;
    logic       out_err;
    logic [7:0] char_cnt;

    int total = 0;
    int bad   = 0;
    logic [5:0] sb [$];

    decifra #(.ALPHA(26), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_err   (key_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err),
        .char_cnt  (char_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] expect_of(input int c, input int k);
        if (c >= 26) return {1'b1, 5'(c)};
        return {1'b0, 5'((c + 26 - k) % 26)};
    endfunction

    task automatic load_key(input logic [4:0] k);
        key_load = 1'b1;
        key_in   = k;
        #1;
        check("load_rdy_low", in_ready, 0);
        tick;
        key_load = 1'b0;
    endtask

    task automatic push_one(input logic [4:0] c);
        in_valid = 1'b1;
        in_code  = c;
        #1;
        check("push_rdy", in_ready, 1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic pop_one(input string tag, input logic [5:0] exp);
        out_ready = 1'b1;
        #1;
        check({tag, "_v"}, out_valid, 1);
        check(tag, {out_err, out_code}, exp);
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; key_load = 1'b0; key_in = '0;
        in_valid = 1'b0; in_code = '0; out_ready = 1'b0;

        // reset state
        #3;
        check("rst_rdy", in_ready, 0);
        check("rst_ov", out_valid, 0);
        check("rst_code", out_code, 0);
        check("rst_err", out_err, 0);
        check("rst_kerr", key_err, 0);
        check("rst_cnt", char_cnt, 0);
        tick; tick;
        reset = 1'b1;
        #1;
        check("idle_rdy", in_ready, 0);

        // key 3, codes 3,0,25 -> 0,23,22
        load_key(5'd3);
        push_one(5'd3);
        check("lat_ov", out_valid, 1);
        check("lat_code", {out_err, out_code}, 6'd0);
        push_one(5'd0);
        push_one(5'd25);
        check("cnt3", char_cnt, 3);
        pop_one("k3_a", 6'd0);
        pop_one("k3_b", 6'd23);
        pop_one("k3_c", 6'd22);
        #1;
        check("empty_ov", out_valid, 0);
        check("hold_code", {out_err, out_code}, 6'd22);

        // key 0, illegal code 30; illegal key 26 rejected
        load_key(5'd0);
        push_one(5'd30);
        pop_one("ill_code", {1'b1, 5'd30});
        key_load = 1'b1; key_in = 5'd26;
        #1;
        check("kerr_hi", key_err, 1);
        tick;
        key_load = 1'b0;
        #1;
        check("kerr_lo", key_err, 0);
        push_one(5'd2);
        pop_one("key_kept", 6'd2);

        // key 5, back-pressure with out_ready low
        load_key(5'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_code = 5'(10 + i);
            #1;
            check("fill_rdy", in_ready, 1);
            tick;
        end
        in_code = 5'd14;
        #1;
        check("full_rdy", in_ready, 0);
        tick;
        check("held_rdy", in_ready, 0);
        check("full_head", {out_err, out_code}, 6'd5);
        out_ready = 1'b1;
        #1;
        check("nobypass_rdy", in_ready, 0);
        tick;
        out_ready = 1'b0;
        #1;
        check("after_pop_rdy", in_ready, 1);
        tick;
        in_valid = 1'b0;
        pop_one("bp_a", 6'd6);
        pop_one("bp_b", 6'd7);
        pop_one("bp_c", 6'd8);
        pop_one("bp_d", 6'd9);
        check("cnt10", char_cnt, 10);

        // key 1, two queued, key change goes through DRAIN
        load_key(5'd1);
        push_one(5'd5);
        push_one(5'd6);
        key_load = 1'b1; key_in = 5'd7;
        #1;
        check("kl_rdy", in_ready, 0);
        tick;
        key_in = 5'd2;
        tick;
        key_load = 1'b0;
        in_valid = 1'b1; in_code = 5'd9;
        #1;
        check("drain_rdy", in_ready, 0);
        tick;
        in_valid = 1'b0;
        pop_one("dr_a", 6'd4);
        check("drain_rdy2", in_ready, 0);
        pop_one("dr_b", 6'd5);
        push_one(5'd4);
        pop_one("newkey", 6'd2);
        check("cnt13", char_cnt, 13);

        // fill, then async reset between edges
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_code = 5'(2 + i);
            tick;
        end
        #2;
        reset = 1'b0;
        #1;
        check("ar_ov", out_valid, 0);
        check("ar_rdy", in_ready, 0);
        check("ar_code", {out_err, out_code}, 6'd0);
        check("ar_cnt", char_cnt, 0);
        #3;
        reset = 1'b1;
        tick;
        check("post_rst_rdy", in_ready, 0);
        check("post_rst_ov", out_valid, 0);
        tick;
        check("post_rst_rdy2", in_ready, 0);
        in_valid = 1'b0;
        load_key(5'd0);
        push_one(5'd7);
        pop_one("post_rst_data", 6'd7);

        // 300 streamed transfers, counter saturates
        load_key(5'd4);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_code = 5'(i % 32);
            #1;
            check("st_v", out_valid, (sb.size() != 0));
            if (sb.size() != 0) check("st_head", {out_err, out_code}, sb.pop_front());
            check("st_rdy", in_ready, 1);
            sb.push_back(expect_of(i % 32, 4));
            tick;
        end
        in_valid = 1'b0;
        #1;
        check("st_last_v", out_valid, 1);
        if (sb.size() != 0) check("st_last", {out_err, out_code}, sb.pop_front());
        tick;
        check("st_drained", out_valid, 0);
        check("sat_cnt", char_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
